noc_local_ni: RTL and testbench
===============================

# noc_local_ni

Local network interface that sits on the L (local) port of a mesh router. It forms the opposite end of the router's local-port protocol. TX side: packs core requests into 40-bit flits, buffers them, and injects them on the router's local input, obeying `full` and local-FIFO pressure. RX side: unpacks every flit the router ejects, checks the destination, computes transit latency, and keeps traffic counters.

## Interface
Parameters
- `DATASIZE`, 40, flit width; layout [39:36] src, [35:32] dst, [31:24] timestamp, [23:2] data, [1:0] type
- `WIDTH`, 3, pressure field is `WIDTH+1` bits
- `NODE_ID`, 4'hC, this node's address, inserted as src and checked as dst
- `QDEPTH`, 4, TX queue entries (power of 2)
- `PRESS_TH`, 6, injection is held while router local pressure ≥ this value

Ports
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tx_valid` in 1: core has a request.
- `tx_ready` out 1: queue can accept; equals `count < QDEPTH`.
- `tx_dst` in 4: destination node.
- `tx_payload` in 22: data field.
- `tx_type` in 2: flit type.
- `L_data_in` out DATASIZE: flit to router local input.
- `L_valid_in` out 1: flit valid to router.
- `full` in 1: router local FIFO full.
- `L_pressure` in WIDTH+1: router local FIFO occupancy.
- `L_data_out` in DATASIZE: flit ejected by router.
- `L_valid_out` in 1: ejected flit valid. No backpressure exists; the NI must accept it every cycle.
- `rx_valid` out 1: one-cycle pulse, unpacked flit present.
- `rx_src` out 4, `rx_payload` out 22, `rx_type` out 2: unpacked fields.
- `rx_latency` out 8: `ts_now − flit_timestamp`, computed mod 256.
- `rx_misroute` out 1: asserted with `rx_valid` when flit dst ≠ NODE_ID.
- `tx_count`, `rx_count`, `err_count` out 16 each: saturating counters.

## Operation
- `ts_now`: 8-bit free-running counter. Increments every cycle and wraps 255→0.
- Enqueue: on `tx_valid & tx_ready`, write `{NODE_ID, tx_dst, ts_now, tx_payload, tx_type}` into the circular queue at `wr_ptr`.
- The queue has no bypass. When the queue is full, `tx_ready` is 0 even if a pop occurs that cycle.
- Injection FSM states:
  - IDLE: queue empty.
  - SEND: head valid, `full=0`, and `L_pressure < PRESS_TH`.
  - HOLD: head valid, but `full=1` or pressure ≥ PRESS_TH.
- Transitions are evaluated each cycle from the current queue count and the router inputs.
- `L_valid_in = (state==SEND)`, driven combinationally from the registered head valid, `full`, and `L_pressure`.
- `L_data_in` = queue head, held stable in HOLD.
- A flit transfers in every cycle where `L_valid_in=1`. Pop occurs and `tx_count` increments in that cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- RX: on `L_valid_out`, register the fields.
  - Next cycle: `rx_valid=1`, `rx_latency = ts_now_at_capture − flit[31:24]`, `rx_misroute = (flit[35:32]≠NODE_ID)`.
  - `rx_count` increments for every flit. `err_count` increments on misroute.
- Back-to-back ejected flits produce back-to-back `rx_valid` pulses, with none dropped.
- Counters saturate at 16'hFFFF.
- Reset:
  - State is IDLE; queue is empty with pointers 0.
  - `ts_now`=0 and all counters are 0.
  - `tx_ready` is 1 in the first cycle after reset.
  - All other outputs are 0, including `L_data_in` and all rx fields.
  - Reset mid-operation discards queued flits with no partial injection. `L_valid_in` is 0 in the cycle after `rst` is sampled high.

## Timing
- TX latency with empty queue and router not full: accept at edge N → `L_valid_in=1` in the cycle after edge N.
- Sustained throughput is 1 flit/cycle while `full=0` and pressure < PRESS_TH.
- `full` or pressure rising blocks `L_valid_in` in the same cycle, because the gating is combinational.
- RX latency: `L_valid_out` sampled at edge N → `rx_valid` and fields valid for exactly the cycle after edge N.
- Timestamp wrap: a flit stamped 250 and received at `ts_now`=4 reports `rx_latency`=10.

## Test plan
- Reset then single request (dst=3, payload=22'h1ABCD, type=2): next cycle `L_valid_in=1` and `L_data_in={4'hC,4'h3,ts,22'h1ABCD,2'b10}`; `tx_count`=1.
- Push 5 requests back-to-back with `full=1`: the first 4 are accepted and `tx_ready`=0 on the 5th. Release `full`: 4 flits go out in 4 consecutive cycles in FIFO order.
- `L_pressure`=6 with queue non-empty: `L_valid_in` stays 0 and data is held. Pressure drops to 5: injection resumes in the same cycle.
- Eject flits to dst=C and then dst=5 on consecutive cycles: two `rx_valid` pulses, with `rx_misroute` 0 then 1; `rx_count`=2 and `err_count`=1.
- Eject a flit with timestamp 250 while `ts_now`=4: `rx_latency`=10.
- Assert `rst` with 3 flits queued and `full=1`: `L_valid_in`=0, `tx_ready`=1, all counters 0, and no stale flit is injected afterwards.

Source files
------------

// File: rtl/noc_local_ni.sv
// noc_local_ni: local network interface on the L port of a mesh router.
//
// TX side: packs core requests into flits {src, dst, timestamp, data, type}. It queues them
// in a QDEPTH-entry circular buffer and injects the head on the router local input. Injection
// is gated combinationally by `full` and the router's local-FIFO pressure.
// RX side: captures every ejected flit and presents the unpacked fields for one cycle. It also
// reports transit latency (mod 256) and a misroute flag, and keeps saturating traffic counters.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   tx_valid / tx_ready           core request handshake (tx_ready = queue not full)
//   tx_dst, tx_payload, tx_type   request fields
//   L_data_in, L_valid_in         flit to router local input
//   full, L_pressure              router local FIFO full flag / occupancy
//   L_data_out, L_valid_out       flit ejected by router (no backpressure)
//   rx_valid, rx_src, rx_payload, rx_type, rx_latency, rx_misroute   unpacked RX flit
//   tx_count, rx_count, err_count saturating 16-bit traffic counters
module noc_local_ni #(
   parameter int unsigned DATASIZE = 40,
   parameter int unsigned WIDTH    = 3,
   parameter logic [3:0]  NODE_ID  = 4'hC,
   parameter int unsigned QDEPTH   = 4,
   parameter int unsigned PRESS_TH = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tx_valid,
   output logic                tx_ready,
   input  logic [3:0]          tx_dst,
   input  logic [21:0]         tx_payload,
   input  logic [1:0]          tx_type,
   output logic [DATASIZE-1:0] L_data_in,
   output logic                L_valid_in,
   input  logic                full,
   input  logic [WIDTH:0]      L_pressure,
   input  logic [DATASIZE-1:0] L_data_out,
   input  logic                L_valid_out,
   output logic                rx_valid,
   output logic [3:0]          rx_src,
   output logic [21:0]         rx_payload,
   output logic [1:0]          rx_type,
   output logic [7:0]          rx_latency,
   output logic                rx_misroute,
   output logic [15:0]         tx_count,
   output logic [15:0]         rx_count,
   output logic [15:0]         err_count
);

   // QDEPTH is a power of two (>= 2), so the pointers wrap naturally.
   localparam int unsigned PtrW = $clog2(QDEPTH);
   localparam int unsigned CntW = $clog2(QDEPTH) + 1;
   localparam logic [CntW-1:0] DepthC  = CntW'(QDEPTH);
   localparam logic [WIDTH:0]  PressTh = (WIDTH+1)'(PRESS_TH);

   typedef enum logic [1:0] {StIdle, StSend, StHold} state_e;

   logic [DATASIZE-1:0] mem_q [QDEPTH];
   logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]     count_q;
   logic [7:0]          ts_now_q;
   logic                head_valid, push, pop;
   logic [DATASIZE-1:0] flit_in;
   state_e              state;

   assign head_valid = (count_q != '0);
   // No bypass: a full queue refuses a push even when the head leaves this cycle.
   assign tx_ready   = (count_q < DepthC);
   assign push       = tx_valid & tx_ready;
   assign flit_in    = DATASIZE'({NODE_ID, tx_dst, ts_now_q, tx_payload, tx_type});

   // Injection state is a pure function of the registered occupancy and the live router
   // inputs, so a rising `full` or pressure blocks injection in the same cycle.
   always_comb begin
      state = StIdle;
      if (head_valid) begin
         if (!full && (L_pressure < PressTh)) state = StSend;
         else                                 state = StHold;
      end
   end

   assign L_valid_in = (state == StSend);
   assign pop        = L_valid_in;
   assign L_data_in  = head_valid ? mem_q[rd_ptr_q] : '0;

   // Queue storage needs no reset; occupancy is tracked by count_q.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= flit_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ts_now_q <= '0;
         tx_count <= '0;
      end else begin
         ts_now_q <= ts_now_q + 8'd1;
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         if (push && !pop)      count_q <= count_q + CntW'(1);
         else if (pop && !push) count_q <= count_q - CntW'(1);
         if (pop && (tx_count != 16'hFFFF)) tx_count <= tx_count + 16'd1;
      end
   end

   // RX capture: fields are presented for exactly the cycle after L_valid_out is sampled.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_valid    <= 1'b0;
         rx_src      <= '0;
         rx_payload  <= '0;
         rx_type     <= '0;
         rx_latency  <= '0;
         rx_misroute <= 1'b0;
         rx_count    <= '0;
         err_count   <= '0;
      end else begin
         rx_valid    <= L_valid_out;
         rx_misroute <= L_valid_out && (L_data_out[35:32] != NODE_ID);
         if (L_valid_out) begin
            rx_src     <= L_data_out[39:36];
            rx_payload <= L_data_out[23:2];
            rx_type    <= L_data_out[1:0];
            rx_latency <= ts_now_q - L_data_out[31:24];
            if (rx_count != 16'hFFFF) rx_count <= rx_count + 16'd1;
            if ((L_data_out[35:32] != NODE_ID) && (err_count != 16'hFFFF)) begin
               err_count <= err_count + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_noc_local_ni.sv
module tb_noc_local_ni;

   logic        clk = 1'b0;
   logic        rst;
   logic        tx_valid;
   logic        tx_ready;
   logic [3:0]  tx_dst;
   logic [21:0] tx_payload;
   logic [1:0]  tx_type;
   logic [39:0] L_data_in;
   logic        L_valid_in;
   logic        full;
   logic [3:0]  L_pressure;
   logic [39:0] L_data_out;
   logic        L_valid_out;
   logic        rx_valid;
   logic [3:0]  rx_src;
   logic [21:0] rx_payload;
   logic [1:0]  rx_type;
   logic [7:0]  rx_latency;
   logic        rx_misroute;
   logic [15:0] tx_count, rx_count, err_count;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: state after the most recent rising edge.
   bit [39:0] m_q[$];
   bit [7:0]  m_ts;
   bit [15:0] m_txc, m_rxc, m_errc;
   bit        m_rx_v, m_rx_mis;
   bit [3:0]  m_rx_src;
   bit [21:0] m_rx_pay;
   bit [1:0]  m_rx_type;
   bit [7:0]  m_rx_lat;

   noc_local_ni dut (
      .clk(clk), .rst(rst),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dst(tx_dst),
      .tx_payload(tx_payload), .tx_type(tx_type),
      .L_data_in(L_data_in), .L_valid_in(L_valid_in), .full(full), .L_pressure(L_pressure),
      .L_data_out(L_data_out), .L_valid_out(L_valid_out),
      .rx_valid(rx_valid), .rx_src(rx_src), .rx_payload(rx_payload), .rx_type(rx_type),
      .rx_latency(rx_latency), .rx_misroute(rx_misroute),
      .tx_count(tx_count), .rx_count(rx_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Advance the model by one edge from the current inputs, then cross the edge.
   task automatic tick();
      bit push, pop;
      if (rst) begin
         m_q.delete();
         m_ts = 0; m_txc = 0; m_rxc = 0; m_errc = 0;
         m_rx_v = 0; m_rx_mis = 0; m_rx_src = 0; m_rx_pay = 0; m_rx_type = 0; m_rx_lat = 0;
      end else begin
         push = tx_valid && (m_q.size() < 4);
         pop  = (m_q.size() > 0) && !full && (L_pressure < 4'd6);
         if (pop) begin
            void'(m_q.pop_front());
            if (m_txc != 16'hFFFF) m_txc++;
         end
         if (push) m_q.push_back({4'hC, tx_dst, m_ts, tx_payload, tx_type});
         m_rx_v   = L_valid_out;
         m_rx_mis = L_valid_out && (L_data_out[35:32] != 4'hC);
         if (L_valid_out) begin
            m_rx_src  = L_data_out[39:36];
            m_rx_pay  = L_data_out[23:2];
            m_rx_type = L_data_out[1:0];
            m_rx_lat  = m_ts - L_data_out[31:24];
            if (m_rxc != 16'hFFFF) m_rxc++;
            if (L_data_out[35:32] != 4'hC && m_errc != 16'hFFFF) m_errc++;
         end
         m_ts++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      tx_valid = 0; tx_dst = 0; tx_payload = 0; tx_type = 0;
      full = 0; L_pressure = 0; L_data_out = 0; L_valid_out = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      idle_inputs();
      tick(); tick();
      rst = 0;
      #1;
      n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
      n_cmp++; if (L_valid_in !== 1'b0) begin n_fail++; $display("FAIL reset_valid_in: got %b want 0", L_valid_in); end
      n_cmp++; if (L_data_in !== 40'h0) begin n_fail++; $display("FAIL reset_data_in: got %h want 0", L_data_in); end
      n_cmp++; if (rx_valid !== 1'b0 || rx_misroute !== 1'b0) begin n_fail++; $display("FAIL reset_rx_flags: got %b%b want 00", rx_valid, rx_misroute); end
      n_cmp++; if ({rx_src, rx_payload, rx_type, rx_latency} !== 36'h0) begin n_fail++; $display("FAIL reset_rx_fields: got %h want 0", {rx_src, rx_payload, rx_type, rx_latency}); end
      n_cmp++; if ({tx_count, rx_count, err_count} !== 48'h0) begin n_fail++; $display("FAIL reset_counters: got %h want 0", {tx_count, rx_count, err_count}); end
   endtask

   task automatic test_single();
      bit [39:0] exp;
      tx_valid = 1; tx_dst = 4'h3; tx_payload = 22'h1ABCD; tx_type = 2'b10;
      exp = {4'hC, 4'h3, m_ts, 22'h1ABCD, 2'b10};
      tick();
      tx_valid = 0;
      #1;
      n_cmp++; if (L_valid_in !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", L_valid_in); end
      n_cmp++; if (L_data_in !== exp) begin n_fail++; $display("FAIL single_data: got %h want %h", L_data_in, exp); end
      tick();
      n_cmp++; if (tx_count !== 16'd1) begin n_fail++; $display("FAIL single_tx_count: got %0d want 1", tx_count); end
      n_cmp++; if (L_valid_in !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %b want 0", L_valid_in); end
   endtask

   task automatic test_full_backpressure();
      bit [39:0] exp[$];
      full = 1;
      for (int i = 0; i < 5; i++) begin
         tx_valid = 1; tx_dst = 4'($urandom); tx_payload = 22'($urandom); tx_type = 2'($urandom);
         #1;
         n_cmp++;
         if (tx_ready !== (i < 4)) begin n_fail++; $display("FAIL fifo_ready[%0d]: got %b want %b", i, tx_ready, (i < 4)); end
         if (i < 4) exp.push_back({4'hC, tx_dst, m_ts, tx_payload, tx_type});
         tick();
      end
      tx_valid = 0; full = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++;
         if (L_valid_in !== 1'b1 || L_data_in !== exp[i]) begin
            n_fail++; $display("FAIL fifo_order[%0d]: got v=%b %h want v=1 %h", i, L_valid_in, L_data_in, exp[i]);
         end
         tick();
      end
      n_cmp++; if (L_valid_in !== 1'b0) begin n_fail++; $display("FAIL fifo_empty: got %b want 0", L_valid_in); end
   endtask

   task automatic test_pressure();
      bit [39:0] exp;
      L_pressure = 4'd6;
      tx_valid = 1; tx_dst = 4'h9; tx_payload = 22'($urandom); tx_type = 2'b01;
      exp = {4'hC, 4'h9, m_ts, tx_payload, 2'b01};
      tick();
      tx_valid = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (L_valid_in !== 1'b0 || L_data_in !== exp) begin
            n_fail++; $display("FAIL press_hold[%0d]: got v=%b %h want v=0 %h", i, L_valid_in, L_data_in, exp);
         end
         tick();
      end
      L_pressure = 4'd5;
      #1;
      n_cmp++; if (L_valid_in !== 1'b1) begin n_fail++; $display("FAIL press_resume: got %b want 1", L_valid_in); end
      tick();
      L_pressure = 0;
   endtask

   task automatic test_rx_misroute();
      bit [15:0] rc0, ec0;
      rc0 = m_rxc; ec0 = m_errc;
      L_valid_out = 1; L_data_out = {4'h7, 4'hC, m_ts - 8'd3, 22'h2A5A5, 2'b11};
      tick();
      L_data_out = {4'h2, 4'h5, m_ts - 8'd1, 22'h01234, 2'b00};
      #1;
      n_cmp++;
      if (rx_valid !== 1'b1 || rx_misroute !== 1'b0 || rx_src !== 4'h7 || rx_payload !== 22'h2A5A5
          || rx_type !== 2'b11 || rx_latency !== 8'd3) begin
         n_fail++; $display("FAIL rx_first: got v=%b m=%b s=%h p=%h t=%b l=%0d want 1 0 7 2a5a5 11 3",
                            rx_valid, rx_misroute, rx_src, rx_payload, rx_type, rx_latency);
      end
      tick();
      L_valid_out = 0;
      #1;
      n_cmp++;
      if (rx_valid !== 1'b1 || rx_misroute !== 1'b1 || rx_src !== 4'h2 || rx_latency !== 8'd1) begin
         n_fail++; $display("FAIL rx_second: got v=%b m=%b s=%h l=%0d want 1 1 2 1", rx_valid, rx_misroute, rx_src, rx_latency);
      end
      tick();
      n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_pulse_end: got %b want 0", rx_valid); end
      n_cmp++; if (rx_count !== rc0 + 16'd2 || err_count !== ec0 + 16'd1) begin
         n_fail++; $display("FAIL rx_counters: got %0d/%0d want %0d/%0d", rx_count, err_count, rc0 + 16'd2, ec0 + 16'd1);
      end
   endtask

   task automatic test_ts_wrap();
      int guard = 0;
      while (m_ts != 8'd4 && guard < 300) begin tick(); guard++; end
      L_valid_out = 1; L_data_out = {4'h1, 4'hC, 8'd250, 22'h3FFFF, 2'b01};
      tick();
      L_valid_out = 0;
      #1;
      n_cmp++; if (rx_valid !== 1'b1 || rx_latency !== 8'd10) begin
         n_fail++; $display("FAIL ts_wrap: got v=%b lat=%0d want v=1 lat=10", rx_valid, rx_latency);
      end
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         tx_valid = ($urandom_range(0, 3) != 0);
         tx_dst = 4'($urandom); tx_payload = 22'($urandom); tx_type = 2'($urandom);
         full = ($urandom_range(0, 4) == 0);
         L_pressure = 4'($urandom_range(0, 7));
         L_valid_out = ($urandom_range(0, 1) == 1);
         L_data_out = {4'($urandom), ($urandom_range(0, 1) == 1) ? 4'hC : 4'($urandom), 32'($urandom)};
         #1;
         n_cmp++; if (tx_ready !== (m_q.size() < 4)) begin
            n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", c, tx_ready, (m_q.size() < 4));
         end
         n_cmp++; if (L_valid_in !== ((m_q.size() > 0) && !full && L_pressure < 4'd6)) begin
            n_fail++; $display("FAIL rand_valid_in[%0d]: got %b", c, L_valid_in);
         end
         if (m_q.size() > 0) begin
            n_cmp++; if (L_data_in !== m_q[0]) begin
               n_fail++; $display("FAIL rand_head[%0d]: got %h want %h", c, L_data_in, m_q[0]);
            end
         end
         n_cmp++; if (rx_valid !== m_rx_v || rx_misroute !== m_rx_mis) begin
            n_fail++; $display("FAIL rand_rx_flags[%0d]: got %b%b want %b%b", c, rx_valid, rx_misroute, m_rx_v, m_rx_mis);
         end
         if (m_rx_v) begin
            n_cmp++; if ({rx_src, rx_payload, rx_type, rx_latency} !== {m_rx_src, m_rx_pay, m_rx_type, m_rx_lat}) begin
               n_fail++; $display("FAIL rand_rx_fields[%0d]: got %h want %h", c,
                                  {rx_src, rx_payload, rx_type, rx_latency}, {m_rx_src, m_rx_pay, m_rx_type, m_rx_lat});
            end
         end
         tick();
      end
      idle_inputs();
      #1;
      n_cmp++; if ({tx_count, rx_count, err_count} !== {m_txc, m_rxc, m_errc}) begin
         n_fail++; $display("FAIL rand_counters: got %0d/%0d/%0d want %0d/%0d/%0d",
                            tx_count, rx_count, err_count, m_txc, m_rxc, m_errc);
      end
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      for (int i = 0; i < 4; i++) tick();  // drain leftovers
      full = 1;
      for (int i = 0; i < 3; i++) begin
         tx_valid = 1; tx_dst = 4'($urandom); tx_payload = 22'($urandom); tx_type = 2'($urandom);
         tick();
      end
      tx_valid = 0;
      rst = 1;
      tick();
      rst = 0;
      #1;
      n_cmp++; if (L_valid_in !== 1'b0 || tx_ready !== 1'b1) begin
         n_fail++; $display("FAIL midreset_flags: got v=%b r=%b want v=0 r=1", L_valid_in, tx_ready);
      end
      n_cmp++; if ({tx_count, rx_count, err_count} !== 48'h0) begin
         n_fail++; $display("FAIL midreset_counters: got %h want 0", {tx_count, rx_count, err_count});
      end
      full = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++; if (L_valid_in !== 1'b0) begin
            n_fail++; $display("FAIL midreset_stale[%0d]: got %b want 0", i, L_valid_in);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_full_backpressure();
      test_pressure();
      test_rx_misroute();
      test_ts_wrap();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
